// File: rtl/branch_resolve_unit_if.sv
// Interface: branch_resolve_unit_if
// Purpose : Groups the fetch push, execute resolve, BTB write and redirect
//           signals of branch_resolve_unit into one bundle.
// Modports:
//   master : fetch/execute side (drives fetch_* and resolve_*, observes the rest)
//   slave  : branch_resolve_unit (consumes fetch_* and resolve_*, drives the rest)
interface branch_resolve_unit_if;
  logic        fetch_valid;
  logic [15:0] fetch_pc;
  logic        fetch_hit;
  logic [15:0] fetch_predicted_pc;
  logic        fetch_stall;
  logic        resolve_valid;
  logic        resolve_is_branch;
  logic        resolve_taken;
  logic [15:0] resolve_target;
  logic [15:0] btb_write_pc;
  logic [15:0] btb_write_data;
  logic        btb_taken;
  logic        flush;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] mispredict_count;

  modport master (
    output fetch_valid, fetch_pc, fetch_hit, fetch_predicted_pc,
    output resolve_valid, resolve_is_branch, resolve_taken, resolve_target,
    input  fetch_stall, btb_write_pc, btb_write_data, btb_taken,
    input  flush, redirect, redirect_pc, mispredict_count
  );

  modport slave (
    input  fetch_valid, fetch_pc, fetch_hit, fetch_predicted_pc,
    input  resolve_valid, resolve_is_branch, resolve_taken, resolve_target,
    output fetch_stall, btb_write_pc, btb_write_data, btb_taken,
    output flush, redirect, redirect_pc, mispredict_count
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Module : branch_resolve_unit
// Purpose: Update-side partner of the BTB. Queues fetch-time predictions in
//          order, checks each one when execute resolves it, writes corrected
//          targets into the BTB and flushes/redirects fetch on a mispredict.
// Ports  :
//   clk   - clock
//   reset - synchronous active-high reset
//   brif  - branch_resolve_unit_if.slave (fetch push, resolve, BTB write,
//           flush/redirect, saturating mispredict counter)
module branch_resolve_unit #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_resolve_unit_if.slave brif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [AW:0]   head_q, head_d, tail_q, tail_d;

  logic [15:0]   pc_q  [DEPTH];
  logic          hit_q [DEPTH];
  logic [15:0]   ppc_q [DEPTH];

  logic          btb_taken_q, flush_q, redirect_q;
  logic [15:0]   btb_write_pc_q, btb_write_data_q, redirect_pc_q, count_q;

  logic          full, empty, push, pop, mispredict_now, write_now;
  logic [15:0]   head_pc, head_ppc, pred_next, act_next;
  logic          head_hit;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (head_q == tail_q);
  assign full  = (head_q[AW] != tail_q[AW]) && (head_q[AW-1:0] == tail_q[AW-1:0]);

  assign head_pc  = pc_q[head_q[AW-1:0]];
  assign head_hit = hit_q[head_q[AW-1:0]];
  assign head_ppc = ppc_q[head_q[AW-1:0]];

  assign pop       = brif.resolve_valid && !empty && (state_q == IDLE);
  assign pred_next = head_hit ? head_ppc : head_pc + 16'd2;
  assign act_next  = (brif.resolve_is_branch && brif.resolve_taken) ? brif.resolve_target
                                                                    : head_pc + 16'd2;
  assign mispredict_now = pop && (pred_next != act_next);

  // A push into a full queue is fine when the head leaves in the same cycle;
  // a push that coincides with a mispredict belongs to the squashed path.
  assign push = brif.fetch_valid && (state_q == IDLE) && (!full || pop) && !mispredict_now;

  // Not-taken hits are left in the BTB: it has no invalidate port.
  assign write_now = pop && brif.resolve_is_branch && brif.resolve_taken &&
                     (!head_hit || (head_ppc != brif.resolve_target));

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (mispredict_now) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
    end
  end

  // Record storage needs no reset; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[tail_q[AW-1:0]]  <= brif.fetch_pc;
      hit_q[tail_q[AW-1:0]] <= brif.fetch_hit;
      ppc_q[tail_q[AW-1:0]] <= brif.fetch_predicted_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      head_q           <= '0;
      tail_q           <= '0;
      btb_taken_q      <= 1'b0;
      btb_write_pc_q   <= '0;
      btb_write_data_q <= '0;
      flush_q          <= 1'b0;
      redirect_q       <= 1'b0;
      redirect_pc_q    <= '0;
      count_q          <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      btb_taken_q <= write_now;
      redirect_q  <= 1'b0;
      if (write_now) begin
        btb_write_pc_q   <= head_pc;
        btb_write_data_q <= brif.resolve_target;
      end
      if (mispredict_now && (count_q != '1)) count_q <= count_q + 16'd1;
      case (state_q)
        IDLE: begin
          if (mispredict_now) begin
            state_q       <= FLUSH;
            cnt_q         <= CW'(FLUSH_CYCLES - 1);
            flush_q       <= 1'b1;
            redirect_q    <= 1'b1;
            redirect_pc_q <= act_next;
          end
        end
        FLUSH: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign brif.fetch_stall      = full;
  assign brif.btb_taken        = btb_taken_q;
  assign brif.btb_write_pc     = btb_write_pc_q;
  assign brif.btb_write_data   = btb_write_data_q;
  assign brif.flush            = flush_q;
  assign brif.redirect         = redirect_q;
  assign brif.redirect_pc      = redirect_pc_q;
  assign brif.mispredict_count = count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
  logic clk = 1'b0;
  logic reset;
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  branch_resolve_unit_if brif ();

  branch_resolve_unit #(.DEPTH(4), .FLUSH_CYCLES(2)) dut (
    .clk  (clk),
    .reset(reset),
    .brif (brif)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    brif.fetch_valid        = 1'b0;
    brif.fetch_pc           = '0;
    brif.fetch_hit          = 1'b0;
    brif.fetch_predicted_pc = '0;
    brif.resolve_valid      = 1'b0;
    brif.resolve_is_branch  = 1'b0;
    brif.resolve_taken      = 1'b0;
    brif.resolve_target     = '0;
  endtask

  task automatic set_push(input logic [15:0] pc, input logic hit, input logic [15:0] ppc);
    brif.fetch_valid        = 1'b1;
    brif.fetch_pc           = pc;
    brif.fetch_hit          = hit;
    brif.fetch_predicted_pc = ppc;
  endtask

  task automatic set_resolve(input logic br, input logic tk, input logic [15:0] tgt);
    brif.resolve_valid     = 1'b1;
    brif.resolve_is_branch = br;
    brif.resolve_taken     = tk;
    brif.resolve_target    = tgt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_in();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_flush",    16'(brif.flush), 16'd0);
    chk("rst_redirect", 16'(brif.redirect), 16'd0);
    chk("rst_btb_tk",   16'(brif.btb_taken), 16'd0);
    chk("rst_stall",    16'(brif.fetch_stall), 16'd0);
    chk("rst_count",    brif.mispredict_count, 16'h0000);
    chk("rst_rpc",      brif.redirect_pc, 16'h0000);
    chk("rst_wpc",      brif.btb_write_pc, 16'h0000);
    reset = 1'b0;

    // 1: non-branch, correct fall-through prediction
    set_push(16'h3000, 1'b0, 16'h0000); tick(); idle_in();
    set_resolve(1'b0, 1'b0, 16'h0000); tick(); idle_in();
    chk("t1_btb_tk",   16'(brif.btb_taken), 16'd0);
    chk("t1_flush",    16'(brif.flush), 16'd0);
    chk("t1_redirect", 16'(brif.redirect), 16'd0);
    // queue is empty: this resolve must be ignored
    set_resolve(1'b1, 1'b1, 16'h1234); tick(); idle_in();
    chk("t1_empty_btb", 16'(brif.btb_taken), 16'd0);
    chk("t1_empty_red", 16'(brif.redirect), 16'd0);
    chk("t1_empty_cnt", brif.mispredict_count, 16'd0);

    // 2: BTB miss, taken branch -> write + redirect
    set_push(16'h3010, 1'b0, 16'h0000); tick(); idle_in();
    set_resolve(1'b1, 1'b1, 16'h3040); tick(); idle_in();
    chk("t2_btb_tk",   16'(brif.btb_taken), 16'd1);
    chk("t2_wpc",      brif.btb_write_pc, 16'h3010);
    chk("t2_wdata",    brif.btb_write_data, 16'h3040);
    chk("t2_redirect", 16'(brif.redirect), 16'd1);
    chk("t2_rpc",      brif.redirect_pc, 16'h3040);
    chk("t2_flush1",   16'(brif.flush), 16'd1);
    chk("t2_count",    brif.mispredict_count, 16'd1);
    tick();
    chk("t2_flush2",   16'(brif.flush), 16'd1);
    chk("t2_red_drop", 16'(brif.redirect), 16'd0);
    chk("t2_btb_drop", 16'(brif.btb_taken), 16'd0);
    chk("t2_wpc_hold", brif.btb_write_pc, 16'h3010);
    tick();
    chk("t2_flush_end", 16'(brif.flush), 16'd0);

    // 3: correct taken hit, then not-taken hit
    set_push(16'h3010, 1'b1, 16'h3040); tick(); idle_in();
    set_resolve(1'b1, 1'b1, 16'h3040); tick(); idle_in();
    chk("t3_hit_btb",   16'(brif.btb_taken), 16'd0);
    chk("t3_hit_flush", 16'(brif.flush), 16'd0);
    chk("t3_hit_count", brif.mispredict_count, 16'd1);
    set_push(16'h3010, 1'b1, 16'h3040); tick(); idle_in();
    set_resolve(1'b1, 1'b0, 16'h0000); tick(); idle_in();
    chk("t3_nt_red",   16'(brif.redirect), 16'd1);
    chk("t3_nt_rpc",   brif.redirect_pc, 16'h3012);
    chk("t3_nt_btb",   16'(brif.btb_taken), 16'd0);
    chk("t3_nt_count", brif.mispredict_count, 16'd2);
    tick();
    tick();
    chk("t3_flush_end", 16'(brif.flush), 16'd0);

    // 4: fill queue, overflow drop, push+pop while full
    for (int i = 0; i < 4; i++) begin
      set_push(16'h4000 + 16'(2 * i), 1'b0, 16'h0000); tick();
    end
    idle_in();
    chk("t4_full_stall", 16'(brif.fetch_stall), 16'd1);
    set_push(16'h4008, 1'b0, 16'h0000); tick(); idle_in();
    chk("t4_drop_stall", 16'(brif.fetch_stall), 16'd1);
    set_push(16'h400A, 1'b0, 16'h0000);
    set_resolve(1'b0, 1'b0, 16'h0000); tick(); idle_in();
    chk("t4_pp_stall", 16'(brif.fetch_stall), 16'd1);
    chk("t4_pp_flush", 16'(brif.flush), 16'd0);
    set_resolve(1'b0, 1'b0, 16'h0000); tick(); idle_in();
    chk("t4_drain_stall", 16'(brif.fetch_stall), 16'd0);
    set_resolve(1'b0, 1'b0, 16'h0000); tick();
    set_resolve(1'b0, 1'b0, 16'h0000); tick();
    chk("t4_order_flush", 16'(brif.flush), 16'd0);
    // last record must be 0x400A (0x4008 was dropped)
    set_resolve(1'b1, 1'b1, 16'h5000); tick(); idle_in();
    chk("t4_last_btb", 16'(brif.btb_taken), 16'd1);
    chk("t4_last_wpc", brif.btb_write_pc, 16'h400A);
    chk("t4_last_rpc", brif.redirect_pc, 16'h5000);
    chk("t4_count",    brif.mispredict_count, 16'd3);
    tick();
    tick();

    // 5: mispredict with younger records queued and same-cycle push
    for (int i = 0; i < 4; i++) begin
      set_push(16'h6000 + 16'(2 * i), 1'b0, 16'h0000); tick();
    end
    idle_in();
    set_push(16'h6008, 1'b0, 16'h0000);
    set_resolve(1'b1, 1'b1, 16'h7000); tick(); idle_in();
    chk("t5_redirect", 16'(brif.redirect), 16'd1);
    chk("t5_rpc",      brif.redirect_pc, 16'h7000);
    chk("t5_stall",    16'(brif.fetch_stall), 16'd0);
    chk("t5_count",    brif.mispredict_count, 16'd4);
    set_push(16'h6100, 1'b0, 16'h0000);
    set_resolve(1'b0, 1'b0, 16'h0000); tick();
    chk("t5_fl_flush", 16'(brif.flush), 16'd1);
    chk("t5_fl_red",   16'(brif.redirect), 16'd0);
    tick(); idle_in();
    chk("t5_fl_end",   16'(brif.flush), 16'd0);
    chk("t5_fl_stall", 16'(brif.fetch_stall), 16'd0);
    set_resolve(1'b1, 1'b1, 16'h1111); tick(); idle_in();
    chk("t5_empty_red", 16'(brif.redirect), 16'd0);
    chk("t5_empty_btb", 16'(brif.btb_taken), 16'd0);
    chk("t5_empty_cnt", brif.mispredict_count, 16'd4);

    // 6: counter saturation and PC wrap
    force dut.count_q = 16'hFFFE;
    #1;
    release dut.count_q;
    tick();
    chk("t6_preload", brif.mispredict_count, 16'hFFFE);
    set_push(16'hFFFE, 1'b1, 16'h1234); tick(); idle_in();
    set_resolve(1'b1, 1'b0, 16'h0000); tick(); idle_in();
    chk("t6_wrap_rpc", brif.redirect_pc, 16'h0000);
    chk("t6_wrap_btb", 16'(brif.btb_taken), 16'd0);
    chk("t6_cnt1",     brif.mispredict_count, 16'hFFFF);
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      set_push(16'h8000, 1'b0, 16'h0000); tick(); idle_in();
      set_resolve(1'b1, 1'b1, 16'h9000); tick(); idle_in();
      chk("t6_sat_red", 16'(brif.redirect), 16'd1);
      chk("t6_sat_cnt", brif.mispredict_count, 16'hFFFF);
      tick();
      tick();
    end

    // mid-operation reset
    set_push(16'hA000, 1'b0, 16'h0000); tick();
    set_push(16'hA002, 1'b0, 16'h0000); tick(); idle_in();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_count", brif.mispredict_count, 16'h0000);
    chk("mr_rpc",   brif.redirect_pc, 16'h0000);
    set_resolve(1'b1, 1'b1, 16'hB000); tick(); idle_in();
    chk("mr_empty_red", 16'(brif.redirect), 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
